// File: rtl/bcd_hex_display.sv
// Sequential double-dabble binary-to-BCD converter driving registered active-low 7-seg codes.
// Define BCD_HEX_LEAD_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module bcd_hex_display #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    value,
    input  logic                ovf_in,
    output logic                done,
    output logic                ovf_out,
    output logic [7*DIGITS-1:0] hex_out
);

    localparam int               BCD_W     = 4 * DIGITS;
    localparam int               CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(WIDTH - 1);
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;
    localparam logic [6:0]       SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]    bin_q;
    logic [BCD_W-1:0]    bcd_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_cap_q;
    logic                sticky_q;
    logic [BCD_W-1:0]    bcd_adj;
    logic [7*DIGITS-1:0] hex_next;
    logic                nibbles_ok;
`ifdef BCD_HEX_LEAD_BLANK_EN
    logic                seen_nonzero;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0011000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: defaults first in every always_comb so no path leaves a variable unassigned (no latches).
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = SHIFT;
            end
            SHIFT:   if (cnt_q == '0) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        hex_next   = '1;
        nibbles_ok = 1'b1;
`ifdef BCD_HEX_LEAD_BLANK_EN
        seen_nonzero = 1'b0;
`endif
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] > 4'd9) nibbles_ok = 1'b0;
        end
        if (ovf_cap_q || sticky_q) begin
            for (int i = 0; i < DIGITS; i++) hex_next[7*i +: 7] = SEG_DASH;
        end else begin
`ifdef BCD_HEX_LEAD_BLANK_EN
            for (int i = DIGITS - 1; i >= 0; i--) begin
                if (bcd_q[4*i +: 4] != 4'd0 || i == 0) seen_nonzero = 1'b1;
                hex_next[7*i +: 7] = seen_nonzero ? seg7(bcd_q[4*i +: 4]) : SEG_BLANK;
            end
`else
            for (int i = 0; i < DIGITS; i++) hex_next[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
`endif
        end
    end

    // NOTE: the conversion datapath carries no reset; the FSM returning to IDLE is what discards it.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (in_valid) begin
                    bin_q     <= value;
                    ovf_cap_q <= ovf_in;
                    bcd_q     <= '0;
                    sticky_q  <= 1'b0;
                    cnt_q     <= CNT_INIT;
                end
            end
            SHIFT: begin
                {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                if (bcd_adj[BCD_W-1]) sticky_q <= 1'b1;
                cnt_q <= cnt_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Display registers only change on the LOAD edge, so the digits hold steady while shifting.
    always_ff @(posedge clk) begin
        if (reset) begin
            done    <= 1'b0;
            ovf_out <= 1'b0;
            hex_out <= '1;
        end else begin
            done <= 1'b0;
            if (state == LOAD) begin
                hex_out <= hex_next;
                ovf_out <= ovf_cap_q | sticky_q;
                done    <= 1'b1;
            end
        end
    end

    a_nibbles_bcd: assert property (@(posedge clk) disable iff (reset) (state == LOAD) |-> nibbles_ok);

endmodule
